// File: rtl/lab_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding and
// default timing constants derived from a 100 MHz system clock.
package lab_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    DB_RELEASE = 3'd4
  } btn_state_e;

  localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 2_000_000;   // 20 ms
  localparam int unsigned DEFAULT_REPEAT_DELAY    = 50_000_000;  // 0.5 s
  localparam int unsigned DEFAULT_REPEAT_PERIOD   = 10_000_000;  // 100 ms

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/inc_pulse_gen_if.sv
// Button-side signal bundle of inc_pulse_gen: raw button in, conditioned
// strobe/level/repeat flags out, plus the FSM state for observation.
interface inc_pulse_gen_if;
  import lab_pkg::*;

  logic       btn_in;
  logic       inc_pulse;
  logic       btn_level;
  logic       repeating;
  btn_state_e dbg_state;

  modport master (
    output btn_in,
    input  inc_pulse, btn_level, repeating, dbg_state
  );

  modport slave (
    input  btn_in,
    output inc_pulse, btn_level, repeating, dbg_state
  );
endinterface

// File: rtl/sync_chain.sv
// Parameterised flop chain bringing an asynchronous input into the clock
// domain; all stages clear on synchronous reset.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/inc_pulse_gen.sv
// Push-button conditioner: synchronise, debounce press/release in one FSM and
// emit one registered inc_pulse per press. INC_PULSE_GEN_AUTO_REPEAT_EN adds auto-repeat.
module inc_pulse_gen
  import lab_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic            clock,
  input  logic            reset,
  inc_pulse_gen_if.slave  bus
);

`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
  localparam int unsigned MAX_CYCLES = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
`else
  localparam int unsigned MAX_CYCLES = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned CNT_W = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
`endif

  logic             btn_sync;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inc_pulse_q, inc_pulse_d;
  logic             btn_level_q, btn_level_d;
  logic             pulse_raw;
`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
  logic             was_repeat_q, was_repeat_d;
  logic             repeating_q, repeating_d;
`endif

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (bus.btn_in),
    .q_o   (btn_sync)
  );

  // State register plus the registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      inc_pulse_q  <= 1'b0;
      btn_level_q  <= 1'b0;
`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
      was_repeat_q <= 1'b0;
      repeating_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inc_pulse_q  <= inc_pulse_d;
      btn_level_q  <= btn_level_d;
`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
      was_repeat_q <= was_repeat_d;
      repeating_q  <= repeating_d;
`endif
    end
  end

  // Next state; a btn_sync change always takes priority over a terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
    was_repeat_d = was_repeat_q;
`endif
    case (state_q)
      IDLE: begin
        if (btn_sync) state_d = DB_PRESS;
      end
      DB_PRESS: begin
        if (!btn_sync)               state_d = IDLE;
        else if (cnt_q == DEB_LAST)  state_d = HELD;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      HELD: begin
        if (!btn_sync) begin
          state_d = DB_RELEASE;
`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
          was_repeat_d = 1'b0;
        end else if (cnt_q == RD_LAST) begin
          state_d = REPEAT;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
      REPEAT: begin
        if (!btn_sync) begin
          state_d      = DB_RELEASE;
          was_repeat_d = 1'b1;
        end else if (cnt_q == RP_LAST) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      DB_RELEASE: begin
        if (btn_sync) begin
`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
          state_d = was_repeat_q ? REPEAT : HELD;
`else
          state_d = HELD;
`endif
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are computed from the transition being taken and registered.
  always_comb begin
    pulse_raw = 1'b0;
    if (state_q == DB_PRESS && state_d == HELD) pulse_raw = 1'b1;
`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
    if (state_q == HELD && state_d == REPEAT) pulse_raw = 1'b1;
    if (state_q == REPEAT && state_d == REPEAT && cnt_q == RP_LAST) pulse_raw = 1'b1;
    repeating_d = (state_d == REPEAT) || (state_d == DB_RELEASE && was_repeat_d);
`endif
    // Guards against back-to-back strobes with degenerate repeat timing.
    inc_pulse_d = pulse_raw & ~inc_pulse_q;
    btn_level_d = (state_d == HELD) || (state_d == REPEAT) || (state_d == DB_RELEASE);
  end

  assign bus.inc_pulse = inc_pulse_q;
  assign bus.btn_level = btn_level_q;
  assign bus.dbg_state = state_q;
`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
  assign bus.repeating = repeating_q;
`else
  assign bus.repeating = 1'b0;
`endif

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Directed bench for inc_pulse_gen: stimulus pushes expected pulse cycles into
// a queue, a negedge monitor pops and compares each observed pulse.
module tb_inc_pulse_gen;
  import lab_pkg::*;

`ifdef INC_PULSE_GEN_AUTO_REPEAT_EN
  localparam logic REP = 1'b1;
`else
  localparam logic REP = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [31:0] cyc;
  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];
  logic [31:0] t;

  inc_pulse_gen_if bus ();

  inc_pulse_gen #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Clock and edge counter: cyc equals the number of rising edges so far.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = '0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Monitor: every observed pulse must match the oldest expected pulse cycle.
  always @(negedge clock) begin
    if (bus.inc_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
      end else begin
        chk("pulse_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bus.btn_in = 1'b0;
    tick(3);
    chk("reset_pulse", 32'(bus.inc_pulse), 0);
    chk("reset_level", 32'(bus.btn_level), 0);
    chk("reset_repeating", 32'(bus.repeating), 0);
    chk("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    reset = 1'b0;
    tick(2);

    // Clean press held 10 cycles: pulse at +7, level falls 7 edges after release drive.
    t = cyc;
    bus.btn_in = 1'b1;
    exp_q.push_back(t + 7);
    tick(10);
    chk("clean_level_high", 32'(bus.btn_level), 1);
    bus.btn_in = 1'b0;
    tick(6);
    chk("clean_level_before_fall", 32'(bus.btn_level), 1);
    tick(1);
    chk("clean_level_fell", 32'(bus.btn_level), 0);
    tick(5);

    // Short 3-cycle press is a glitch: no pulse, level stays low.
    bus.btn_in = 1'b1;
    tick(3);
    bus.btn_in = 1'b0;
    tick(2);
    chk("glitch_level_mid", 32'(bus.btn_level), 0);
    tick(6);
    chk("glitch_level_after", 32'(bus.btn_level), 0);

    // Bouncing press, then stable: one pulse timed from the last rise.
    for (int i = 0; i < 6; i++) begin
      bus.btn_in = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick(1);
    end
    t = cyc;
    bus.btn_in = 1'b1;
    exp_q.push_back(t + 7);
    tick(12);
    chk("bounce_level_high", 32'(bus.btn_level), 1);
    bus.btn_in = 1'b0;
    tick(10);
    chk("bounce_level_low", 32'(bus.btn_level), 0);

    // Long hold: auto-repeat pulses at +20 then every 8 after the press pulse.
    t = cyc;
    bus.btn_in = 1'b1;
    exp_q.push_back(t + 7);
    if (REP) begin
      for (int i = 0; i < 5; i++) exp_q.push_back(t + 27 + 8 * i);
    end
    tick(26);
    chk("hold_repeating_before", 32'(bus.repeating), 0);
    tick(1);
    chk("hold_repeating_after", 32'(bus.repeating), 32'(REP));
    tick(36);
    bus.btn_in = 1'b0;
    tick(5);
    chk("hold_repeating_in_release", 32'(bus.repeating), 32'(REP));
    tick(3);
    chk("hold_repeating_cleared", 32'(bus.repeating), 0);
    chk("hold_level_cleared", 32'(bus.btn_level), 0);
    tick(4);

    // Reset mid-hold with the button still pressed: must re-debounce.
    t = cyc;
    bus.btn_in = 1'b1;
    exp_q.push_back(t + 7);
    if (REP) exp_q.push_back(t + 27);
    tick(30);
    chk("pre_reset_repeating", 32'(bus.repeating), 32'(REP));
    reset = 1'b1;
    tick(1);
    chk("midreset_pulse", 32'(bus.inc_pulse), 0);
    chk("midreset_level", 32'(bus.btn_level), 0);
    chk("midreset_repeating", 32'(bus.repeating), 0);
    reset = 1'b0;
    exp_q.push_back(t + 38);
    tick(12);
    chk("post_reset_level_high", 32'(bus.btn_level), 1);
    bus.btn_in = 1'b0;
    tick(10);
    chk("post_reset_level_low", 32'(bus.btn_level), 0);

    tick(5);
    chk("expected_pulses_left", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
